// File: rtl/instr_encoder.sv
// instr_encoder: turns one decoded Y86-64 instruction (icode, ifun, rA, rB,
// valC) into its byte image and writes it, one byte per cycle, into a
// byte-wide instruction memory at a running write pointer.
//
// Handshake: an instruction is accepted on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE. Fields are sampled
// at that edge only; later input changes are ignored until the next accept.
// A rejected accept pulses err on the following cycle and leaves in_ready
// high, so a new accept can happen in the err cycle.
module instr_encoder #(
    parameter int                 ADDR_W     = 10,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              done,
    output logic              err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // One-valued constants at the pointer widths
    localparam logic [ADDR_W:0]   FILL_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    // Fill level equal to the whole memory (2^ADDR_W)
    localparam logic [ADDR_W:0]   FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    // Instruction length in bytes; 0 marks an unknown icode
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        logic [3:0] len;
        case (ic)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
            4'h7, 4'h8:             len = 4'd9;
            4'h3, 4'h4, 4'h5:       len = 4'd10;
            default:                len = 4'd0;
        endcase
        return len;
    endfunction

    // Byte k of the instruction image
    function automatic logic [7:0] instr_byte(
        input logic [3:0]  ic,
        input logic [3:0]  fn,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] vc,
        input logic [3:0]  k
    );
        logic [7:0]  b;
        logic [3:0]  fn_e;
        logic [3:0]  ra_e;
        logic [3:0]  rb_e;
        logic        has_reg;
        logic        valc_at1;
        logic        valc_at2;
        logic [63:0] sh;
        b        = 8'h00;
        sh       = 64'h0;
        // only cmovXX, OPq and jXX carry a meaningful function code
        fn_e     = (ic == 4'h2 || ic == 4'h6 || ic == 4'h7) ? fn : 4'h0;
        // irmovq has no source register; pushq/popq have no second register
        ra_e     = (ic == 4'h3) ? 4'hF : ra;
        rb_e     = (ic == 4'hA || ic == 4'hB) ? 4'hF : rb;
        has_reg  = (ic >= 4'h2 && ic <= 4'h6) || ic == 4'hA || ic == 4'hB;
        valc_at1 = (ic == 4'h7 || ic == 4'h8);
        valc_at2 = (ic == 4'h3 || ic == 4'h4 || ic == 4'h5);
        if (k == 4'd0) begin
            b = {ic, fn_e};
        end else if (has_reg && k == 4'd1) begin
            b = {ra_e, rb_e};
        end else if (valc_at1 && k <= 4'd8) begin
            sh = vc >> {k - 4'd1, 3'b000};
            b  = sh[7:0];
        end else if (valc_at2 && k >= 4'd2 && k <= 4'd9) begin
            sh = vc >> {k - 4'd2, 3'b000};
            b  = sh[7:0];
        end
        return b;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          icode_q, icode_d;
    logic [3:0]          ifun_q, ifun_d;
    logic [3:0]          ra_q, ra_d;
    logic [3:0]          rb_q, rb_d;
    logic [63:0]         valc_q, valc_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                full_q, full_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [3:0]          in_len;
    logic [ADDR_W:0]     fill_end;
    logic                fits;

    // Length and memory-fit check of the instruction currently offered
    always_comb begin
        in_len   = instr_len(icode);
        fill_end = {full_q, wr_ptr_q} + {{(ADDR_W-3){1'b0}}, in_len};
        fits     = (fill_end <= FILL_MAX);
    end

    // Next-state, pointer and write-port logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        len_d       = len_q;
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        valc_d      = valc_q;
        wr_ptr_d    = wr_ptr_q;
        full_d      = full_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_len == 4'd0 || !fits) begin
                        err_d = 1'b1;
                    end else begin
                        icode_d     = icode;
                        ifun_d      = ifun;
                        ra_d        = rA;
                        rb_d        = rB;
                        valc_d      = valC;
                        len_d       = in_len;
                        // byte 0 goes out straight from the accept edge
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_ptr_q;
                        mem_wdata_d = instr_byte(icode, ifun, rA, rB, valC, 4'd0);
                        done_d      = (in_len == 4'd1);
                        k_d         = 4'd1;
                        state_d     = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                // the byte on the port this cycle is committed: advance
                {full_d, wr_ptr_d} = {full_q, wr_ptr_q} + FILL_ONE;
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q + ADDR_ONE;
                    mem_wdata_d = instr_byte(icode_q, ifun_q, ra_q, rb_q, valc_q, k_q);
                    done_d      = (k_q == len_q - 4'd1);
                    k_d         = k_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= 4'd0;
            len_q       <= 4'd0;
            icode_q     <= 4'd0;
            ifun_q      <= 4'd0;
            ra_q        <= 4'd0;
            rb_q        <= 4'd0;
            valc_q      <= 64'd0;
            wr_ptr_q    <= START_ADDR;
            full_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= START_ADDR;
            mem_wdata_q <= 8'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            len_q       <= len_d;
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            valc_q      <= valc_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_ptr    = wr_ptr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 1 KiB instance starting at 0 and a
// 16-byte instance starting at 12 for the end-of-memory cases.
module tb_instr_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        in_valid = 1'b0;
    logic [3:0]  icode = '0, ifun = '0, ra = '0, rb = '0;
    logic [63:0] valc = '0;
    logic        in_ready, mem_we, done, err;
    logic [9:0]  mem_addr, wr_ptr;
    logic [7:0]  mem_wdata;

    logic        s_in_valid = 1'b0;
    logic [3:0]  s_icode = '0, s_ifun = '0, s_ra = '0, s_rb = '0;
    logic [63:0] s_valc = '0;
    logic        s_in_ready, s_mem_we, s_done, s_err;
    logic [3:0]  s_mem_addr, s_wr_ptr;
    logic [7:0]  s_mem_wdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both_cnt = 0;

    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         wc_q[$];
    int         dc_q[$];
    int         ec_q[$];

    instr_encoder #(.ADDR_W(10), .START_ADDR(10'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(ra), .rB(rb), .valC(valc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wr_ptr(wr_ptr), .done(done), .err(err)
    );

    instr_encoder #(.ADDR_W(4), .START_ADDR(4'd12)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .icode(s_icode), .ifun(s_ifun), .rA(s_ra), .rB(s_rb), .valC(s_valc),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .wr_ptr(s_wr_ptr), .done(s_done), .err(s_err)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write / done / err log of the main instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
                wc_q.push_back(cyc);
            end
            if (done) dc_q.push_back(cyc);
            if (err)  ec_q.push_back(cyc);
            if ((done && err) || (s_done && s_err)) both_cnt <= both_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // offer one instruction to the main instance; t = accept cycle
    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] vc, output int t);
        icode    = ic;
        ifun     = fn;
        ra       = a;
        rb       = b;
        valc     = vc;
        in_valid = 1'b1;
        t        = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_idle: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
        total++; if (mem_we !== 1'b0)      begin bad++; $display("FAIL reset_mem_we: got=%b exp=0", mem_we); end
        total++; if (mem_addr !== 10'd0)   begin bad++; $display("FAIL reset_mem_addr: got=%0h exp=0", mem_addr); end
        total++; if (mem_wdata !== 8'd0)   begin bad++; $display("FAIL reset_mem_wdata: got=%0h exp=0", mem_wdata); end
        total++; if (wr_ptr !== 10'd0)     begin bad++; $display("FAIL reset_wr_ptr: got=%0h exp=0", wr_ptr); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got=%b%b exp=00", done, err); end
        total++; if (s_mem_addr !== 4'd12 || s_wr_ptr !== 4'd12) begin bad++; $display("FAIL reset_small_ptr: got addr=%0d ptr=%0d exp=12/12", s_mem_addr, s_wr_ptr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        logic [79:0] exp_img = 80'h0123456789ABCDEFF330;
        int t;
        int b;
        int db;
        int eb;
        apply_reset();
        b  = wa_q.size();
        db = dc_q.size();
        eb = ec_q.size();
        send(4'h3, 4'h5, 4'h7, 4'h3, 64'h0123456789ABCDEF, t);
        wait_idle(20);
        total++; if (cyc != t + 11) begin bad++; $display("FAIL irmovq_ready_cycle: got=%0d exp=%0d", cyc, t + 11); end
        total++; if (wa_q.size() != b + 10) begin bad++; $display("FAIL irmovq_write_count: got=%0d exp=10", wa_q.size() - b); end
        if (wa_q.size() == b + 10) begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (wa_q[b+i] !== 10'(i) || wd_q[b+i] !== exp_img[8*i +: 8] || wc_q[b+i] != t + 1 + i) begin
                    bad++;
                    $display("FAIL irmovq_byte%0d: got addr=%0d data=%0h cyc=%0d exp addr=%0d data=%0h cyc=%0d",
                             i, wa_q[b+i], wd_q[b+i], wc_q[b+i], i, exp_img[8*i +: 8], t + 1 + i);
                end
            end
        end
        total++; if (dc_q.size() != db + 1 || dc_q[dc_q.size()-1] != t + 10) begin bad++; $display("FAIL irmovq_done: got count=%0d exp 1 at %0d", dc_q.size() - db, t + 10); end
        total++; if (ec_q.size() != eb) begin bad++; $display("FAIL irmovq_no_err: got=%0d exp=0", ec_q.size() - eb); end
        total++; if (wr_ptr !== 10'd10) begin bad++; $display("FAIL irmovq_wr_ptr: got=%0d exp=10", wr_ptr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[5] = '{8'h00, 8'h60, 8'h23, 8'hA0, 8'h4F};
        int exp_c[5];
        int t0, t1, t2;
        int b;
        apply_reset();
        b = wa_q.size();
        send(4'h0, 4'h3, 4'h1, 4'h1, 64'h0, t0);
        wait_idle(20);
        send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, t1);
        wait_idle(20);
        send(4'hA, 4'h5, 4'h4, 4'h0, 64'h0, t2);
        wait_idle(20);
        exp_c = '{t0 + 1, t1 + 1, t1 + 2, t2 + 1, t2 + 2};
        total++; if (t1 != t0 + 2 || t2 != t1 + 3) begin bad++; $display("FAIL b2b_gap: got accepts %0d,%0d,%0d exp %0d,%0d", t0, t1, t2, t0 + 2, t0 + 5); end
        total++; if (wa_q.size() != b + 5) begin bad++; $display("FAIL b2b_write_count: got=%0d exp=5", wa_q.size() - b); end
        if (wa_q.size() == b + 5) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (wa_q[b+i] !== 10'(i) || wd_q[b+i] !== exp_d[i] || wc_q[b+i] != exp_c[i]) begin
                    bad++;
                    $display("FAIL b2b_byte%0d: got addr=%0d data=%0h cyc=%0d exp addr=%0d data=%0h cyc=%0d",
                             i, wa_q[b+i], wd_q[b+i], wc_q[b+i], i, exp_d[i], exp_c[i]);
                end
            end
        end
        total++; if (wr_ptr !== 10'd5) begin bad++; $display("FAIL b2b_wr_ptr: got=%0d exp=5", wr_ptr); end
    endtask

    task automatic test_jump_call();
        logic [7:0] exp_d[18] = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                  8'h80, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        int t0, t1;
        int b;
        apply_reset();
        b = wa_q.size();
        send(4'h7, 4'h0, 4'h5, 4'h6, 64'h40, t0);
        wait_idle(20);
        send(4'h8, 4'h3, 4'h1, 4'h2, 64'h1234, t1);
        wait_idle(20);
        total++; if (wa_q.size() != b + 18) begin bad++; $display("FAIL jc_write_count: got=%0d exp=18", wa_q.size() - b); end
        if (wa_q.size() == b + 18) begin
            for (int i = 0; i < 18; i++) begin
                total++;
                if (wa_q[b+i] !== 10'(i) || wd_q[b+i] !== exp_d[i]) begin
                    bad++;
                    $display("FAIL jc_byte%0d: got addr=%0d data=%0h exp addr=%0d data=%0h",
                             i, wa_q[b+i], wd_q[b+i], i, exp_d[i]);
                end
            end
        end
        total++; if (wr_ptr !== 10'd18) begin bad++; $display("FAIL jc_wr_ptr: got=%0d exp=18", wr_ptr); end
    endtask

    // continues from wr_ptr=18
    task automatic test_reject();
        icode    = 4'hC;
        ifun     = 4'h0;
        ra       = 4'h1;
        rb       = 4'h2;
        valc     = 64'h55;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++; if (err !== 1'b1)      begin bad++; $display("FAIL rej_err: got=%b exp=1", err); end
        total++; if (mem_we !== 1'b0)   begin bad++; $display("FAIL rej_mem_we: got=%b exp=0", mem_we); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rej_in_ready: got=%b exp=1", in_ready); end
        total++; if (wr_ptr !== 10'd18) begin bad++; $display("FAIL rej_wr_ptr: got=%0d exp=18", wr_ptr); end
        icode = 4'h1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (err !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("FAIL rej_nop_accept: got err=%b we=%b exp err=0 we=1", err, mem_we); end
        total++; if (mem_addr !== 10'd18 || mem_wdata !== 8'h10) begin bad++; $display("FAIL rej_nop_byte: got addr=%0d data=%0h exp addr=18 data=10", mem_addr, mem_wdata); end
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL rej_nop_done: got=%b exp=1", done); end
        wait_idle(20);
        total++; if (wr_ptr !== 10'd19) begin bad++; $display("FAIL rej_wr_ptr_after: got=%0d exp=19", wr_ptr); end
    endtask

    // continues from wr_ptr=19
    task automatic test_reset_mid_emit();
        int t;
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, t);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        total++; if (mem_we !== 1'b1 || mem_addr !== 10'd23 || mem_wdata !== 8'h66) begin bad++; $display("FAIL rmm_byte4: got we=%b addr=%0d data=%0h exp we=1 addr=23 data=66", mem_we, mem_addr, mem_wdata); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 8'd0) begin bad++; $display("FAIL rmm_reset_port: got we=%b addr=%0d data=%0h exp 0/0/0", mem_we, mem_addr, mem_wdata); end
        total++; if (wr_ptr !== 10'd0 || in_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rmm_reset_state: got ptr=%0d rdy=%b done=%b exp 0/1/0", wr_ptr, in_ready, done); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, t);
        total++; if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 8'h00 || done !== 1'b1) begin bad++; $display("FAIL rmm_halt: got we=%b addr=%0d data=%0h done=%b exp 1/0/00/1", mem_we, mem_addr, mem_wdata, done); end
        wait_idle(20);
        total++; if (wr_ptr !== 10'd1) begin bad++; $display("FAIL rmm_wr_ptr: got=%0d exp=1", wr_ptr); end
    endtask

    task automatic test_small_mem();
        apply_reset();
        total++; if (s_wr_ptr !== 4'd12) begin bad++; $display("FAIL sm_start: got=%0d exp=12", s_wr_ptr); end
        s_icode    = 4'h3;
        s_rb       = 4'h1;
        s_valc     = 64'h99;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        total++; if (s_err !== 1'b1 || s_mem_we !== 1'b0) begin bad++; $display("FAIL sm_irmov_rej: got err=%b we=%b exp 1/0", s_err, s_mem_we); end
        total++; if (s_wr_ptr !== 4'd12 || s_in_ready !== 1'b1) begin bad++; $display("FAIL sm_irmov_ptr: got ptr=%0d rdy=%b exp 12/1", s_wr_ptr, s_in_ready); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            s_icode    = 4'h1;
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            total++;
            if (s_mem_we !== 1'b1 || s_mem_addr !== 4'(12 + i) || s_mem_wdata !== 8'h10 || s_done !== 1'b1 || s_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL sm_nop%0d: got we=%b addr=%0d data=%0h done=%b rdy=%b exp 1/%0d/10/1/0",
                         i, s_mem_we, s_mem_addr, s_mem_wdata, s_done, s_in_ready, 12 + i);
            end
            @(posedge clk);
            #1;
            total++;
            if (s_wr_ptr !== 4'(13 + i) || s_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL sm_nop%0d_ptr: got ptr=%0d rdy=%b exp %0d/1", i, s_wr_ptr, s_in_ready, (13 + i) % 16);
            end
        end
        s_icode    = 4'h1;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        total++; if (s_err !== 1'b1 || s_mem_we !== 1'b0 || s_wr_ptr !== 4'd0) begin bad++; $display("FAIL sm_full_rej: got err=%b we=%b ptr=%0d exp 1/0/0", s_err, s_mem_we, s_wr_ptr); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_back_to_back();
        test_jump_call();
        test_reject();
        test_reset_mid_emit();
        test_small_mem();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL done_err_overlap: got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
